// File: rtl/sqrt_host_seq_if.sv
// Handshake bundle between the square-root host sequencer and its neighbours:
// operand stream in, result stream out, and the Start/Done link to the sqrt unit.
interface sqrt_host_seq_if #(
    parameter int W  = 8,
    parameter int RW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_data;
    logic          out_err;
    logic          sq_start;
    logic [W-1:0]  sq_operand;
    logic          sq_done;
    logic [RW-1:0] sq_result;

    // The sequencer itself sits on the master side.
    modport master (
        input  in_valid, in_data, out_ready, sq_done, sq_result,
        output in_ready, out_valid, out_data, out_err, sq_start, sq_operand
    );

    modport slave (
        output in_valid, in_data, out_ready, sq_done, sq_result,
        input  in_ready, out_valid, out_data, out_err, sq_start, sq_operand
    );
endinterface

// File: rtl/sqrt_host_seq.sv
// Host-side initiator for the square-root unit: buffers operands in a small FIFO,
// runs one Start/Done exchange at a time and presents each root (or a timeout error).
module sqrt_host_seq #(
    parameter int W       = 8,
    parameter int RW      = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            CLR,
    sqrt_host_seq_if.master bus,
    output logic            busy,
    output logic [7:0]      ops_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, LAUNCH, MASK, WAIT, HOLD} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic [W-1:0]  operand_q, operand_d;
    logic          out_valid_q, out_valid_d;
    logic [RW-1:0] out_data_q, out_data_d;
    logic          out_err_q, out_err_d;
    logic [TW-1:0] wait_q, wait_d;
    logic [7:0]    ops_q, ops_d;
    logic          push, pop;

    // in_ready comes straight off the registered full flag, so a full FIFO
    // refuses a push even in the cycle it is being popped.
    assign push = bus.in_valid & ~full_q;

    always_comb begin
        state_d     = state_q;
        operand_d   = operand_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        wait_d      = wait_q;
        ops_d       = ops_q;
        pop         = 1'b0;

        case (state_q)
            IDLE: begin
                if ((count_q != '0) && !out_valid_q) begin
                    operand_d = mem_q[rptr_q];
                    pop       = 1'b1;
                    state_d   = LAUNCH;
                end
            end
            LAUNCH: state_d = MASK;
            MASK: begin
                // Done may still be high from the previous operation; ignore it here.
                wait_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.sq_done) begin
                    out_data_d  = bus.sq_result;
                    out_err_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end else if (wait_q == TW'(TIMEOUT - 1)) begin
                    out_data_d  = '0;
                    out_err_d   = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            HOLD: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    ops_d       = ops_q + 8'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d = (count_d == CW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (CLR) begin
            state_q     <= IDLE;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            operand_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            wait_q      <= '0;
            ops_q       <= '0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            operand_q   <= operand_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            wait_q      <= wait_d;
            ops_q       <= ops_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= bus.in_data;
        end
    end

    assign bus.in_ready   = ~full_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_err    = out_err_q;
    assign bus.sq_start   = (state_q == LAUNCH);
    assign bus.sq_operand = operand_q;
    assign busy           = (state_q != IDLE) || (count_q != '0);
    assign ops_count      = ops_q;
endmodule

// File: tb/tb_sqrt_host_seq.sv
// Directed bench for sqrt_host_seq with a small behavioural model of the sqrt unit
// whose Done latency, stale-Done behaviour and no-response mode are set per scenario.
module tb_sqrt_host_seq;
    localparam int W  = 8;
    localparam int RW = 4;

    logic       clk = 1'b0;
    logic       CLR = 1'b1;
    logic       busy;
    logic [7:0] ops_count;

    int vectors     = 0;
    int miscompares = 0;

    sqrt_host_seq_if #(.W(W), .RW(RW)) bus ();

    sqrt_host_seq #(.W(W), .RW(RW), .DEPTH(4), .TIMEOUT(64)) dut (
        .clk       (clk),
        .CLR       (CLR),
        .bus       (bus),
        .busy      (busy),
        .ops_count (ops_count)
    );

    always #5 clk = ~clk;

    // Model configuration, written only by the stimulus process.
    int modelLat    = 3;
    bit modelNever  = 1'b0;
    bit modelSticky = 1'b0;

    bit           mActive = 1'b0;
    int           mcnt = 0;
    logic [W-1:0] mOp = '0;
    int           startCount = 0;
    logic [W-1:0] lastStartOp = '0;

    function automatic logic [RW-1:0] isqrt(input logic [W-1:0] v);
        int r = 0;
        while ((r + 1) * (r + 1) <= int'(v)) r++;
        return RW'(r);
    endfunction

    // Sqrt unit model: Done is a level held until the next Start. In sticky mode the
    // previous Done survives through MASK and drops in the first WAIT cycle.
    always @(negedge clk) begin
        if (CLR) begin
            mActive       = 1'b0;
            bus.sq_done   = 1'b0;
            bus.sq_result = '0;
        end else if (bus.sq_start) begin
            startCount++;
            lastStartOp = bus.sq_operand;
            mOp         = bus.sq_operand;
            mActive     = 1'b1;
            mcnt        = 0;
            if (!modelSticky) bus.sq_done = 1'b0;
        end else if (mActive) begin
            mcnt++;
            if (modelSticky && mcnt == 2) bus.sq_done = 1'b0;
            if (!modelNever && mcnt == modelLat) begin
                bus.sq_done   = 1'b1;
                bus.sq_result = isqrt(mOp);
                mActive       = 1'b0;
            end
        end
    end

    task automatic pushOp(input logic [W-1:0] d);
        bit accepted = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int i = 0; i < 200; i++) begin
            if (bus.in_ready) begin
                @(posedge clk);
                accepted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        #1 bus.in_valid = 1'b0;
        vectors++;
        if (!accepted) begin
            miscompares++;
            $display("[TB] FAIL push_accept: operand %0d not accepted, got in_ready=%0b required 1", d, bus.in_ready);
        end
    endtask

    task automatic getResult(output logic [RW-1:0] d, output logic e, output bit ok);
        ok = 1'b0;
        d  = '0;
        e  = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                d  = bus.out_data;
                e  = bus.out_err;
                ok = 1'b1;
                bus.out_ready = 1'b1;
                @(posedge clk);
                #1 bus.out_ready = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        CLR = 1'b1;
        repeat (2) @(posedge clk);
        #1 CLR = 1'b0;
        @(negedge clk);
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_in_ready: got %b required 1", bus.in_ready); end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_out_valid: got %b required 0", bus.out_valid); end
        vectors++; if (bus.sq_start !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_sq_start: got %b required 0", bus.sq_start); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_busy: got %b required 0", busy); end
        vectors++; if (ops_count !== 8'd0) begin miscompares++; $display("[TB] FAIL rst_ops_count: got %0d required 0", ops_count); end
        vectors++; if (bus.out_err !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_out_err: got %b required 0", bus.out_err); end
        vectors++; if (bus.sq_operand !== 8'd0) begin miscompares++; $display("[TB] FAIL rst_sq_operand: got %0d required 0", bus.sq_operand); end
    endtask

    task automatic test_single_op();
        logic [RW-1:0] d;
        logic e;
        bit ok;
        int base;
        modelLat = 3;
        base = startCount;
        pushOp(8'd144);
        getResult(d, e, ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL single_valid: got no out_valid required out_valid=1"); end
        vectors++; if (d !== 4'd12) begin miscompares++; $display("[TB] FAIL single_data: got %0d required 12", d); end
        vectors++; if (e !== 1'b0) begin miscompares++; $display("[TB] FAIL single_err: got %b required 0", e); end
        vectors++; if (startCount - base != 1) begin miscompares++; $display("[TB] FAIL single_start_pulses: got %0d required 1", startCount - base); end
        vectors++; if (lastStartOp !== 8'd144) begin miscompares++; $display("[TB] FAIL single_operand: got %0d required 144", lastStartOp); end
        @(negedge clk);
        vectors++; if (ops_count !== 8'd1) begin miscompares++; $display("[TB] FAIL single_ops_count: got %0d required 1", ops_count); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL single_busy_after: got %b required 0", busy); end
        vectors++; if (bus.sq_operand !== 8'd144) begin miscompares++; $display("[TB] FAIL single_operand_hold: got %0d required 144", bus.sq_operand); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]  ops [5] = '{8'd81, 8'd49, 8'd25, 8'd9, 8'd4};
        logic [RW-1:0] exp [5] = '{4'd9, 4'd7, 4'd5, 4'd3, 4'd2};
        logic [RW-1:0] d;
        logic e;
        bit ok;
        modelLat = 2;
        for (int i = 0; i < 5; i++) pushOp(ops[i]);
        @(negedge clk);
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL full_in_ready: got %b required 0", bus.in_ready); end
        // Offer an extra operand while full; it must never show up as a result.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd16;
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b0;
        vectors++; if (bus.out_valid !== 1'b1 || bus.out_data !== 4'd9) begin miscompares++; $display("[TB] FAIL held_result: got valid=%b data=%0d required valid=1 data=9", bus.out_valid, bus.out_data); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL full_busy: got %b required 1", busy); end
        for (int i = 0; i < 5; i++) begin
            getResult(d, e, ok);
            vectors++;
            if (!ok || d !== exp[i] || e !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL b2b_result%0d: got ok=%b data=%0d err=%b required data=%0d err=0", i, ok, d, e, exp[i]);
            end
        end
        repeat (3) @(negedge clk);
        vectors++; if (ops_count !== 8'd6) begin miscompares++; $display("[TB] FAIL b2b_ops_count: got %0d required 6", ops_count); end
        vectors++; if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_drained: got busy=%b out_valid=%b required 0 0", busy, bus.out_valid); end
    endtask

    task automatic test_stale_done();
        logic [RW-1:0] d;
        logic e;
        bit ok;
        modelSticky = 1'b1;
        modelLat    = 7;
        pushOp(8'd100);
        getResult(d, e, ok);
        modelSticky = 1'b0;
        vectors++; if (!ok || d !== 4'd10) begin miscompares++; $display("[TB] FAIL stale_data: got ok=%b data=%0d required 10", ok, d); end
        vectors++; if (e !== 1'b0) begin miscompares++; $display("[TB] FAIL stale_err: got %b required 0", e); end
        @(negedge clk);
        vectors++; if (ops_count !== 8'd7) begin miscompares++; $display("[TB] FAIL stale_ops_count: got %0d required 7", ops_count); end
    endtask

    task automatic test_timeout();
        logic [RW-1:0] d;
        logic e;
        bit ok;
        bit seen = 1'b0;
        int k = 0;
        int base;
        modelNever = 1'b1;
        modelLat   = 2;
        base = startCount;
        pushOp(8'd200);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.sq_start) begin seen = 1'b1; break; end
        end
        vectors++; if (!seen) begin miscompares++; $display("[TB] FAIL to_start: got no sq_start required one pulse"); end
        // From the LAUNCH cycle: one edge into MASK, one into WAIT, then 64 in WAIT.
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            k++;
            if (bus.out_valid) break;
        end
        vectors++; if (k != 66) begin miscompares++; $display("[TB] FAIL to_latency: got %0d edges after launch required 66", k); end
        vectors++; if (bus.out_err !== 1'b1 || bus.out_data !== 4'd0) begin miscompares++; $display("[TB] FAIL to_flags: got err=%b data=%0d required err=1 data=0", bus.out_err, bus.out_data); end
        pushOp(8'd64);
        repeat (3) @(negedge clk);
        vectors++; if (startCount - base != 1) begin miscompares++; $display("[TB] FAIL to_no_launch_while_held: got %0d starts required 1", startCount - base); end
        modelNever = 1'b0;
        getResult(d, e, ok);
        vectors++; if (!ok || e !== 1'b1 || d !== 4'd0) begin miscompares++; $display("[TB] FAIL to_err_result: got ok=%b err=%b data=%0d required err=1 data=0", ok, e, d); end
        getResult(d, e, ok);
        vectors++; if (!ok || e !== 1'b0 || d !== 4'd8) begin miscompares++; $display("[TB] FAIL to_next_op: got ok=%b err=%b data=%0d required err=0 data=8", ok, e, d); end
        @(negedge clk);
        vectors++; if (ops_count !== 8'd9) begin miscompares++; $display("[TB] FAIL to_ops_count: got %0d required 9", ops_count); end
    endtask

    task automatic test_reset_midop();
        int base;
        modelNever = 1'b1;
        pushOp(8'd50);
        pushOp(8'd60);
        pushOp(8'd70);
        repeat (6) @(negedge clk);
        vectors++; if (busy !== 1'b1 || bus.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_pre_busy: got busy=%b in_ready=%b required 1 1", busy, bus.in_ready); end
        CLR = 1'b1;
        @(posedge clk);
        #1 CLR = 1'b0;
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_busy: got %b required 0", busy); end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_out_valid: got %b required 0", bus.out_valid); end
        vectors++; if (ops_count !== 8'd0) begin miscompares++; $display("[TB] FAIL mid_ops_count: got %0d required 0", ops_count); end
        vectors++; if (bus.sq_operand !== 8'd0) begin miscompares++; $display("[TB] FAIL mid_sq_operand: got %0d required 0", bus.sq_operand); end
        base = startCount;
        repeat (10) @(negedge clk);
        vectors++; if (startCount != base || bus.out_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_queue_flushed: got starts=%0d out_valid=%b busy=%b required 0 0 0", startCount - base, bus.out_valid, busy); end
        modelNever = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single_op();
        test_back_to_back();
        test_stale_done();
        test_timeout();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t required completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
